// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the program loader and processor decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: loader FSM state enum, image geometry constants, instruction width.
package program_loader_pkg;

  // Instruction width, shared with the processor decode.
  localparam int INSTR_W        = 16;
  localparam int PROG_ADDR_W    = 4;
  localparam int PROG_WORDS     = 2 ** PROG_ADDR_W;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Latency: n/a (wiring only).
// Backpressure: byte stream is valid/ready; the write port has no backpressure.
// master = loader (consumes bytes, issues writes); slave = byte source / memory side.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int WORD_W = INSTR_W
) ();

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    input  byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/program_loader_prog_ram.sv
// 16x16 single-port instruction RAM that takes the place of the processor's fixed ROM.
// Latency: write lands on the clock edge with wr_en; read is combinational.
// Backpressure: none; a write is accepted on every cycle wr_en is high.
// Ports: clk, wr_en/wr_addr/wr_data (loader side), rd_addr/rd_data (processor fetch side).
module prog_ram
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int WORD_W = INSTR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Storage only; contents are defined by the loader, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Assembles a big-endian byte stream into 16 instruction words, writes them, verifies an XOR checksum.
// Latency: one write strobe per word two accepted bytes later; 49 cycles start-to-done when streaming.
// Backpressure: byte_ready deasserts during the write cycle and outside a load; unaccepted bytes are dropped.
// Ports: clk, rst_n, start; bus (byte_data/valid/ready in, wr_en/addr/data out); cpu_hold, done, error.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int WORD_W = INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  program_loader_if.master   bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] HI   = ST_HI;
  localparam logic [2:0] LO   = ST_LO;
  localparam logic [2:0] WR   = ST_WR;
  localparam logic [2:0] CHK  = ST_CHK;
  localparam logic [2:0] DONE = ST_DONE;
  localparam logic [2:0] ERR  = ST_ERR;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [2:0]        state_q,      state_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [WORD_W-1:0] wr_data_q,    wr_data_d;
  logic [7:0]        checksum_q,   checksum_d;
  logic              wr_en_q,      wr_en_d;
  logic              byte_ready_q, byte_ready_d;
  logic              done_q,       done_d;
  logic              error_q,      error_d;
  logic              cpu_hold_q,   cpu_hold_d;

  logic              accept;

  // byte_ready_q already reflects the current state, so this is the handshake itself.
  assign accept = bus.byte_valid && byte_ready_q;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HI;
          wr_addr_d  = '0;
          checksum_d = '0;
        end
      end
      HI: begin
        if (accept) begin
          wr_data_d[WORD_W-1 -: 8] = bus.byte_data;
          checksum_d               = checksum_q ^ bus.byte_data;
          state_d                  = LO;
        end
      end
      LO: begin
        if (accept) begin
          wr_data_d[7:0] = bus.byte_data;
          checksum_d     = checksum_q ^ bus.byte_data;
          state_d        = WR;
        end
      end
      WR: begin
        // Address holds at the last word so it never wraps within a load.
        if (wr_addr_q == LAST_ADDR) begin
          state_d = CHK;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
          state_d   = HI;
        end
      end
      CHK: begin
        // The checksum byte itself is compared, not folded in.
        if (accept) begin
          state_d = (bus.byte_data == checksum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every output is registered from the next state, so it is valid in the
    // same cycle as the state it describes.
    wr_en_d      = (state_d == WR);
    byte_ready_d = (state_d == HI) || (state_d == LO) || (state_d == CHK);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
    cpu_hold_d   = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      checksum_q   <= '0;
      wr_en_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      checksum_q   <= checksum_d;
      wr_en_q      <= wr_en_d;
      byte_ready_q <= byte_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with the instruction RAM attached to its write port.
// Latency: n/a.
// Backpressure: byte source waits on byte_ready and can insert idle cycles between bytes.
module tb_program_loader;

  logic clk;
  logic rst_n;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  program_loader_if #(.ADDR_W(4), .WORD_W(16)) bus ();

  program_loader #(.ADDR_W(4), .WORD_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  prog_ram #(.ADDR_W(4), .WORD_W(16)) ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int total_wr = 0;
  int wr_cnt [16];

  logic [15:0] img [16];
  logic [19:0] exp_q [$];   // {addr, data}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Write-port scoreboard: each strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en === 1'b1) begin
      logic [19:0] e;
      total_wr++;
      wr_cnt[bus.wr_addr]++;
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", {12'd0, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, bus.wr_addr}, {28'd0, e[19:16]});
        check("wr_data", {16'd0, bus.wr_data}, {16'd0, e[15:0]});
      end
    end
  end

  function automatic logic [7:0] good_csum();
    logic [7:0] c = 8'h00;
    for (int w = 0; w < 16; w++) c = c ^ img[w][15:8] ^ img[w][7:0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      check("byte_ready_timeout", 32'd0, 32'd1);
      bus.byte_valid = 1'b0;
    end else begin
      tick();
      bus.byte_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full load; optionally pulses start again just before word start_at_word.
  task automatic run_load(input int gap, input logic [7:0] csum, input int start_at_word,
                          output int lat);
    int c0;
    for (int a = 0; a < 16; a++) wr_cnt[a] = 0;
    pulse_start();
    c0 = cyc;
    for (int w = 0; w < 16; w++) begin
      if (w == start_at_word) pulse_start();
      send_byte(img[w][15:8], gap);
      exp_q.push_back({4'(w), img[w]});
      send_byte(img[w][7:0], gap);
    end
    send_byte(csum, gap);
    lat = cyc - c0;
  endtask

  task automatic check_written_once(input string name);
    int bad = 0;
    for (int a = 0; a < 16; a++) if (wr_cnt[a] != 1) bad++;
    check(name, bad, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      if (rd_data !== img[a]) bad++;
    end
    check(name, bad, 0);
  endtask

  typedef struct {
    int         gap;
    logic       use_good;
    logic [7:0] bad_csum;
    logic       exp_done;
    logic       exp_err;
    logic       exp_hold;
  } row_t;

  row_t rows [6];

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int wr0;
    logic [7:0] csum;

    img[0] = 16'hA601; img[1] = 16'hB401; img[2] = 16'h3681;
    img[3] = 16'hF600; img[4] = 16'h8200;
    for (int w = 5; w < 16; w++) img[w] = 16'h0000;

    rows[0] = '{0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};   // streaming
    rows[1] = '{2, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};   // valid 1-0-0 per byte
    rows[2] = '{0, 1'b0, 8'h60, 1'b0, 1'b1, 1'b1};   // bad checksum
    rows[3] = '{0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};   // retry from error
    rows[4] = '{1, 1'b0, 8'h2E, 1'b0, 1'b1, 1'b1};   // bad checksum, gapped
    rows[5] = '{0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};   // reload from error

    rst_n          = 1'b1;
    start          = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    rd_addr        = 4'd0;
    for (int a = 0; a < 16; a++) wr_cnt[a] = 0;

    // Asynchronous reset asserted mid-cycle.
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wr_en",      {31'd0, bus.wr_en},      32'd0);
    check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_done",       {31'd0, done},           32'd0);
    check("rst_error",      {31'd0, error},          32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold},       32'd1);
    check("rst_wr_addr",    {28'd0, bus.wr_addr},    32'd0);
    check("rst_wr_data",    {16'd0, bus.wr_data},    32'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    wr0 = total_wr;
    repeat (20) tick();
    check("idle_no_wr", total_wr - wr0, 0);
    check("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("idle_byte_ready", {31'd0, bus.byte_ready}, 32'd0);

    // Table-driven loads.
    for (int r = 0; r < 6; r++) begin
      csum = rows[r].use_good ? good_csum() : rows[r].bad_csum;
      run_load(rows[r].gap, csum, -1, lat);
      check($sformatf("row%0d_done", r),     {31'd0, done},     {31'd0, rows[r].exp_done});
      check($sformatf("row%0d_error", r),    {31'd0, error},    {31'd0, rows[r].exp_err});
      check($sformatf("row%0d_cpu_hold", r), {31'd0, cpu_hold}, {31'd0, rows[r].exp_hold});
      check_written_once($sformatf("row%0d_wr_once", r));
      if (rows[r].gap == 0) check($sformatf("row%0d_latency", r), lat, 49);
      if (rows[r].exp_done) check_ram($sformatf("row%0d_ram", r));
      tick();
      check($sformatf("row%0d_done_held", r), {31'd0, done}, {31'd0, rows[r].exp_done});
    end

    // Reload from DONE: cpu_hold returns the cycle after start.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("reload_done_clr", {31'd0, done},     32'd0);
    for (int w = 0; w < 16; w++) begin
      send_byte(img[w][15:8], 0);
      exp_q.push_back({4'(w), img[w]});
      send_byte(img[w][7:0], 0);
    end
    send_byte(good_csum(), 0);
    check("reload_done", {31'd0, done}, 32'd1);

    // start pulsed mid-load at word 5 is ignored.
    run_load(0, good_csum(), 5, lat);
    check("midstart_done", {31'd0, done}, 32'd1);
    check_written_once("midstart_wr_once");

    // Reset while the low byte of word 7 is awaited.
    for (int a = 0; a < 16; a++) wr_cnt[a] = 0;
    pulse_start();
    for (int w = 0; w < 7; w++) begin
      send_byte(img[w][15:8], 0);
      exp_q.push_back({4'(w), img[w]});
      send_byte(img[w][7:0], 0);
    end
    send_byte(img[7][15:8], 0);
    check("midrst_in_lo", {31'd0, bus.byte_ready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrst_addr7_unwritten", wr_cnt[7], 0);
    check("midrst_wr_addr",    {28'd0, bus.wr_addr},    32'd0);
    check("midrst_cpu_hold",   {31'd0, cpu_hold},       32'd1);
    check("midrst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("midrst_queue_empty", exp_q.size(), 0);

    // Bytes offered in IDLE are dropped; a following load is unaffected.
    wr0 = total_wr;
    bus.byte_data  = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (5) tick();
    bus.byte_valid = 1'b0;
    check("idle_bytes_ignored", total_wr - wr0, 0);
    run_load(0, good_csum(), -1, lat);
    check("final_done", {31'd0, done}, 32'd1);
    check("final_latency", lat, 49);
    check_written_once("final_wr_once");
    check_ram("final_ram");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
